// File: rtl/mbist_op_seq_pkg.sv
// Shared MBIST definitions for the march-element op sequencer: sizing,
// stimulus field layout and sequencer state encoding.
package mbist_op_seq_pkg;

    localparam int OP_MAX_DEF = 8;

    // Per-op stimulus field: bit 0 invert, bit 1 read, bit 2 write.
    localparam int FIELD_W = 3;
    localparam int INV_OFS = 0;
    localparam int RD_OFS  = 1;
    localparam int WR_OFS  = 2;

    // Element controls sit at the top of the stimulus word, counted down from the MSB.
    localparam int UPDOWN_TOP  = 1;
    localparam int REVERSE_TOP = 2;
    localparam int REPEAT_TOP  = 3;

    function automatic int sti_wd_f(input int op_max);
        return FIELD_W * op_max + 3;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/mbist_op_seq_if.sv
// Handshake bundle between the march controller (master) and the op sequencer (slave).
interface mbist_op_seq_if
    import mbist_op_seq_pkg::*;
#(
    parameter int OP_CNT_W = $clog2(OP_MAX_DEF),
    parameter int STI_WD   = sti_wd_f(OP_MAX_DEF)
);
    logic                start;
    logic                abort;
    logic [STI_WD-1:0]   stimulus;
    logic                op_ack;
    logic                op_valid;
    logic                op_read;
    logic                op_write;
    logic                op_invert;
    logic                op_updown;
    logic                op_reverse;
    logic                op_repeatflag;
    logic [OP_CNT_W-1:0] op_idx;
    logic                last_op;
    logic                elem_done;
    logic                busy;

    modport master (
        output start, abort, stimulus, op_ack,
        input  op_valid, op_read, op_write, op_invert, op_updown, op_reverse,
               op_repeatflag, op_idx, last_op, elem_done, busy
    );

    modport slave (
        input  start, abort, stimulus, op_ack,
        output op_valid, op_read, op_write, op_invert, op_updown, op_reverse,
               op_repeatflag, op_idx, last_op, elem_done, busy
    );
endinterface

// File: rtl/mbist_op_decode.sv
// Selects the current op's read/write/invert bits from the latched stimulus;
// the repeat pass complements the data polarity.
module mbist_op_decode
    import mbist_op_seq_pkg::*;
#(
    parameter int OP_MAX   = OP_MAX_DEF,
    parameter int OP_CNT_W = $clog2(OP_MAX)
) (
    input  logic [FIELD_W*OP_MAX-1:0] sti_q,
    input  logic [OP_CNT_W-1:0]       op_idx,
    input  logic                      pass,
    output logic                      read,
    output logic                      write,
    output logic                      invert
);

    // One-hot style mux over the op fields.
    always_comb begin
        read   = 1'b0;
        write  = 1'b0;
        invert = 1'b0;
        for (int i = 0; i < OP_MAX; i++) begin
            if (op_idx == OP_CNT_W'(i)) begin
                read   = sti_q[FIELD_W*i + RD_OFS];
                write  = sti_q[FIELD_W*i + WR_OFS];
                invert = sti_q[FIELD_W*i + INV_OFS] ^ pass;
            end else begin
            end
        end
    end

endmodule

// File: rtl/mbist_op_seq.sv
// March-element op sequencer: steps through the configured number of ops,
// optionally repeating once with inverted data, and holds each op until acked.
module mbist_op_seq
    import mbist_op_seq_pkg::*;
#(
    parameter int OP_MAX   = OP_MAX_DEF,
    parameter int OP_CNT_W = $clog2(OP_MAX),
    parameter int STI_WD   = sti_wd_f(OP_MAX)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_shift,
    input  logic            sdi,
    output logic            sdo,
    mbist_op_seq_if.slave   bus
);

    localparam logic [OP_CNT_W-1:0] LAST_MAX = OP_CNT_W'(OP_MAX - 1);

    seq_state_e          state_r, state_s;
    logic [OP_CNT_W-1:0] op_idx_r, op_idx_s;
    logic                pass_r, pass_s;
    logic [STI_WD-1:0]   sti_r, sti_s;
    logic [OP_CNT_W-1:0] op_num_m1_r, op_num_m1_s;
    logic [OP_CNT_W-1:0] shifted_s;
    logic [OP_CNT_W-1:0] last_idx_s;
    logic                repeat_s;
    logic                dec_read_s, dec_write_s, dec_invert_s;
    logic                op_valid_s;

    generate
        if (OP_CNT_W > 1) begin : g_shift_wide
            assign shifted_s = {sdi, op_num_m1_r[OP_CNT_W-1:1]};
        end else begin : g_shift_one
            assign shifted_s = sdi;
        end
    endgenerate

    assign repeat_s = sti_r[STI_WD-REPEAT_TOP];

    // Clamp the scanned count so an oversized config still indexes a real op.
    always_comb begin
        if (op_num_m1_r > LAST_MAX) begin
            last_idx_s = LAST_MAX;
        end else begin
            last_idx_s = op_num_m1_r;
        end
    end

    // Scan chain only moves while idle so a running element keeps its count.
    always_comb begin
        if (scan_shift && (state_r == ST_IDLE)) begin
            op_num_m1_s = shifted_s;
        end else begin
            op_num_m1_s = op_num_m1_r;
        end
    end

    // Next-state logic; abort overrides every other input.
    always_comb begin
        state_s  = state_r;
        op_idx_s = op_idx_r;
        pass_s   = pass_r;
        sti_s    = sti_r;
        if (bus.abort) begin
            state_s  = ST_IDLE;
            op_idx_s = '0;
            pass_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && !scan_shift) begin
                        state_s  = ST_RUN;
                        sti_s    = bus.stimulus;
                        op_idx_s = '0;
                        pass_s   = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.op_ack) begin
                        if (op_idx_r != last_idx_s) begin
                            op_idx_s = op_idx_r + OP_CNT_W'(1);
                        end else if (repeat_s && !pass_r) begin
                            pass_s   = 1'b1;
                            op_idx_s = '0;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_s  = ST_IDLE;
                    op_idx_s = '0;
                    pass_s   = 1'b0;
                end
                default: begin
                    state_s  = ST_IDLE;
                    op_idx_s = '0;
                    pass_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counters, latched stimulus and scan register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_idx_r    <= '0;
            pass_r      <= 1'b0;
            sti_r       <= '0;
            op_num_m1_r <= LAST_MAX;
        end else begin
            state_r     <= state_s;
            op_idx_r    <= op_idx_s;
            pass_r      <= pass_s;
            sti_r       <= sti_s;
            op_num_m1_r <= op_num_m1_s;
        end
    end

    mbist_op_decode #(
        .OP_MAX   (OP_MAX),
        .OP_CNT_W (OP_CNT_W)
    ) u_decode (
        .sti_q  (sti_r[FIELD_W*OP_MAX-1:0]),
        .op_idx (op_idx_r),
        .pass   (pass_r),
        .read   (dec_read_s),
        .write  (dec_write_s),
        .invert (dec_invert_s)
    );

    assign op_valid_s        = (state_r == ST_RUN);
    assign bus.op_valid      = op_valid_s;
    assign bus.busy          = (state_r != ST_IDLE);
    assign bus.elem_done     = (state_r == ST_DONE);
    assign bus.op_idx        = op_idx_r;
    assign bus.op_read       = op_valid_s & dec_read_s;
    assign bus.op_write      = op_valid_s & dec_write_s;
    assign bus.op_invert     = op_valid_s & dec_invert_s;
    assign bus.op_updown     = sti_r[STI_WD-UPDOWN_TOP];
    assign bus.op_reverse    = sti_r[STI_WD-REVERSE_TOP];
    assign bus.op_repeatflag = repeat_s;
    assign bus.last_op       = op_valid_s & (op_idx_r == last_idx_s) & (~repeat_s | pass_r);
    assign sdo               = op_num_m1_r[0];

endmodule

// File: tb/tb_mbist_op_seq.sv
// Randomized bench for mbist_op_seq against an op-list reference model.
module tb_mbist_op_seq;
    localparam int OP_MAX = 8;
    localparam int W      = 3;
    localparam int STI    = 3*OP_MAX + 3;

    logic clk, rst_n, scan_shift, sdi, sdo;
    int   n_checks = 0;
    int   n_errors = 0;
    int   op_num;

    mbist_op_seq_if #(.OP_CNT_W(W), .STI_WD(STI)) bus ();

    mbist_op_seq #(.OP_MAX(OP_MAX), .OP_CNT_W(W), .STI_WD(STI)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_shift (scan_shift),
        .sdi        (sdi),
        .sdo        (sdo),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, " busy"},     32'(bus.busy),      32'd0);
        check_val({tag, " op_valid"}, 32'(bus.op_valid),  32'd0);
        check_val({tag, " last_op"},  32'(bus.last_op),   32'd0);
        check_val({tag, " rwi"},      32'({bus.op_read, bus.op_write, bus.op_invert}), 32'd0);
    endtask

    // One scan shift in IDLE, optionally with start held high as well.
    task automatic scan_bit(input bit b, input bit with_start);
        @(negedge clk);
        check_val("sdo_before_shift", 32'(sdo), 32'(op_num & 1));
        scan_shift = 1'b1;
        sdi        = b;
        bus.start  = with_start;
        op_num     = (op_num >> 1) | (int'(b) << (W - 1));
        @(negedge clk);
        scan_shift = 1'b0;
        bus.start  = 1'b0;
        check_val("scan_stays_idle", 32'(bus.busy), 32'd0);
    endtask

    // Runs one element; model expands it into a flat list of (pass, idx) steps.
    task automatic run_element(input logic [STI-1:0] sti, input int abort_at,
                               input bit rand_ack, input bit noisy);
        int count, total, k, cycles, p, i, budget;
        bit rep, ack, ab;
        logic [STI-1:0] lat;
        @(negedge clk);
        bus.stimulus = sti;
        bus.start    = 1'b1;
        bus.op_ack   = 1'b0;
        scan_shift   = 1'b0;
        lat          = sti;
        count  = ((op_num > OP_MAX - 1) ? OP_MAX - 1 : op_num) + 1;
        rep    = lat[STI-3];
        total  = rep ? 2 * count : count;
        budget = total * 20 + 20;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0; cycles = 0; ab = 1'b0;
        while (k < total && !ab && cycles < budget) begin
            p = k / count;
            i = k % count;
            check_val("op_valid",  32'(bus.op_valid),  32'd1);
            check_val("busy",      32'(bus.busy),      32'd1);
            check_val("elem_done", 32'(bus.elem_done), 32'd0);
            check_val("op_idx",    32'(bus.op_idx),    32'(i));
            check_val("op_read",   32'(bus.op_read),   32'(lat[3*i+1]));
            check_val("op_write",  32'(bus.op_write),  32'(lat[3*i+2]));
            check_val("op_invert", 32'(bus.op_invert), 32'(lat[3*i] ^ p[0]));
            check_val("last_op",   32'(bus.last_op),   32'(k == total - 1));
            check_val("elem_ctl",  32'({bus.op_updown, bus.op_reverse, bus.op_repeatflag}),
                      32'(lat[STI-1:STI-3]));
            check_val("sdo_run",   32'(sdo), 32'(op_num & 1));
            if (noisy) begin
                bus.stimulus = ~bus.stimulus;
                scan_shift   = 1'($urandom);
                sdi          = 1'($urandom);
            end
            ack = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (k == abort_at) begin
                bus.abort = 1'b1;
                ab        = 1'b1;
            end
            bus.op_ack = ack;
            @(negedge clk);
            bus.abort = 1'b0;
            if (!ab && ack) k++;
            cycles++;
        end
        bus.op_ack = 1'b0;
        scan_shift = 1'b0;
        if (ab) begin
            check_idle_outputs("abort");
            check_val("abort op_idx",    32'(bus.op_idx),    32'd0);
            check_val("abort elem_done", 32'(bus.elem_done), 32'd0);
            @(negedge clk);
            check_val("abort elem_done2", 32'(bus.elem_done), 32'd0);
        end else if (k < total) begin
            check_val("ack_timeout", 32'(k), 32'(total));
        end else begin
            check_val("done elem_done", 32'(bus.elem_done), 32'd1);
            check_val("done op_valid",  32'(bus.op_valid),  32'd0);
            check_val("done busy",      32'(bus.busy),      32'd1);
            @(negedge clk);
            check_val("done pulse_end", 32'(bus.elem_done), 32'd0);
            check_idle_outputs("after_done");
        end
    endtask

    initial begin
        logic [STI-1:0] s;
        int nshift, ab_at;
        rst_n = 1'b0; scan_shift = 1'b0; sdi = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.op_ack = 1'b0; bus.stimulus = '0;
        op_num = OP_MAX - 1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check_val("reset elem_done", 32'(bus.elem_done), 32'd0);
        check_val("reset op_idx",    32'(bus.op_idx),    32'd0);
        check_val("reset ctl",       32'({bus.op_updown, bus.op_reverse, bus.op_repeatflag}), 32'd0);
        check_val("reset sdo",       32'(sdo), 32'd1);
        rst_n = 1'b1;

        // Eight ops, op0 is a write.
        s = '0; s[2] = 1'b1;
        run_element(s, -1, 1'b0, 1'b0);

        // Scan 0,1,0 -> three ops.
        scan_bit(1'b0, 1'b0); scan_bit(1'b1, 1'b0); scan_bit(1'b0, 1'b0);
        s = STI'($urandom); s[STI-3] = 1'b0;
        run_element(s, -1, 1'b0, 1'b0);

        // Two ops with repeat pass: four acks, inverted second pass.
        scan_bit(1'b1, 1'b0); scan_bit(1'b0, 1'b0); scan_bit(1'b0, 1'b0);
        s = '0; s[STI-3] = 1'b1; s[2] = 1'b1; s[4] = 1'b1; s[3] = 1'b1;
        run_element(s, -1, 1'b0, 1'b0);

        // Back to eight ops, abort together with op_ack at op 4.
        scan_bit(1'b1, 1'b1); scan_bit(1'b1, 1'b1); scan_bit(1'b1, 1'b0);
        s = STI'($urandom); s[STI-3] = 1'b0;
        run_element(s, 4, 1'b0, 1'b0);

        // Stimulus and scan noise while running must not disturb the element.
        run_element(STI'($urandom), -1, 1'b0, 1'b1);

        // Async reset mid-element.
        @(negedge clk);
        bus.stimulus = STI'($urandom); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.op_ack = 1'b1;
        @(negedge clk);
        bus.op_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        check_val("mid_reset elem_done", 32'(bus.elem_done), 32'd0);
        check_val("mid_reset sdo",       32'(sdo), 32'd1);
        op_num = OP_MAX - 1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int e = 0; e < 30; e++) begin
            nshift = $urandom_range(0, 3);
            for (int j = 0; j < nshift; j++) scan_bit(1'($urandom), 1'($urandom));
            @(negedge clk);
            bus.op_ack = 1'b1;
            @(negedge clk);
            bus.op_ack = 1'b0;
            check_val("idle_ack_ignored", 32'({bus.busy, bus.op_valid}), 32'd0);
            ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            run_element(STI'($urandom), ab_at, 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mbist_op_seq.md
MBIST_OP_SEQ -- requirements
Module: mbist_op_seq

Interface
REQ-001 SHALL have parameter OP_MAX, default 8, max operations per march element (2..16).
REQ-002 SHALL have parameter OP_CNT_W, default $clog2(OP_MAX), op index/count width.
REQ-003 SHALL have parameter STI_WD, default 3*OP_MAX+3, stimulus width.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 scan_shift  input  1  shift op-count config chain.
REQ-007 sdi  input  1  scan data in.
REQ-008 sdo  output  1  scan data out = op_num_m1[0].
REQ-009 start  input  1  begin element; sampled only in IDLE.
REQ-010 abort  input  1  synchronous abort, any state.
REQ-011 stimulus  input  STI_WD  per op i: bit 3i invert, 3i+1 read, 3i+2 write; [STI_WD-1] updown, [STI_WD-2] reverse, [STI_WD-3] repeatflag.
REQ-012 op_ack  input  1  current op's address sweep complete.
REQ-013 op_valid  output  1  op fields valid; held until op_ack.
REQ-014 op_read / op_write / op_invert  output  1 each  current op controls.
REQ-015 op_updown / op_reverse / op_repeatflag  output  1 each  latched element controls.
REQ-016 op_idx  output  OP_CNT_W  current op index.
REQ-017 last_op  output  1  current op is final op of element.
REQ-018 elem_done  output  1  one-cycle pulse, element complete.
REQ-019 busy  output  1  state != IDLE.

Function
REQ-020 op_num_m1 (OP_CNT_W bits) SHALL shift {sdi, op_num_m1[W-1:1]} per cycle with scan_shift=1 in IDLE; ignored when busy.
REQ-021 Effective op count SHALL be min(op_num_m1, OP_MAX-1)+1.
REQ-022 FSM states SHALL be IDLE, RUN, DONE.
REQ-023 IDLE: start=1 and scan_shift=0 -> RUN; sti_q <= stimulus, op_idx <= 0, pass <= 0; scan_shift has priority over start.
REQ-024 RUN: op_valid=1; op fields from sti_q at op_idx; stimulus changes during RUN SHALL not affect outputs.
REQ-025 RUN, op_ack, op_idx < last index -> op_idx +1, stay RUN; op_valid stays high (back-to-back ops, one cycle per ack).
REQ-026 RUN, op_ack, op_idx = last index, repeatflag=1, pass=0 -> pass <= 1, op_idx <= 0, stay RUN.
REQ-027 RUN, op_ack, op_idx = last index, otherwise -> DONE.
REQ-028 DONE: elem_done=1 for exactly one cycle -> IDLE; op_valid=0.
REQ-029 op_invert SHALL equal sti_q[3*op_idx] XOR pass (repeat pass runs complemented data).
REQ-030 last_op SHALL equal op_valid AND op_idx = last index AND (repeatflag=0 OR pass=1).
REQ-031 abort=1 SHALL force IDLE next cycle, op_idx=0, pass=0, no elem_done; abort beats op_ack and start.
REQ-032 op_ack outside RUN SHALL be ignored.
REQ-033 Single-op element (count 1): one op_ack -> DONE (or second pass if repeatflag).
REQ-034 In IDLE, op_read/op_write/op_invert SHALL be 0.

Reset
REQ-035 rst_n low SHALL set IDLE, op_idx=0, pass=0, sti_q=0, op_num_m1=OP_MAX-1.
REQ-036 Reset values: op_valid, last_op, elem_done, busy, all op_* outputs = 0; sdo = op_num_m1[0] (1 for OP_MAX=8).
REQ-037 Reset mid-RUN SHALL abandon element, no elem_done.

Structure
REQ-038 OP_MAX default, STI_WD derivation, stimulus field offsets and FSM state enum SHALL live in the shared MBIST definitions package.
REQ-039 Field extraction SHALL be one combinational sub-module mbist_op_decode (sti_q, op_idx, pass -> read/write/invert); FSM, counters and scan register in mbist_op_seq.

Verification (OP_MAX=8)
REQ-040 Reset, start with stimulus op0 = write (bit2=1), 8 acks -> op_idx 0..7, last_op on idx 7, elem_done one cycle after 8th ack.
REQ-041 Scan sdi 0,1,0 (op_num_m1=3'b010) -> 3 ops; sdo shows prior bits 1,1,1; third ack -> elem_done.
REQ-042 repeatflag=1, count 2, op0 invert=0 -> 4 acks; op_invert 0,x,1,x; last_op only on 4th op.
REQ-043 abort with op_ack same cycle at op_idx=4 -> IDLE, op_idx=0, no elem_done.
REQ-044 start and scan_shift both 1 in IDLE -> scan shifts, state stays IDLE; scan_shift while busy -> op_num_m1 unchanged.
REQ-045 stimulus toggled every cycle during RUN -> op outputs match value latched at start.
